// File: rtl/ppu_types_pkg.sv
// Shared PPU type definitions: VRAM ownership and arbiter state encodings,
// plus the constants used by the VRAM arbiter.
package ppu_types_pkg;

    typedef enum logic [1:0] {
        NONE,
        BG,
        OBJ,
        CPU
    } vram_owner_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam int         VRAM_AW  = 13;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the BG fetcher, the sprite fetcher and the
// CPU. One transaction at a time: grant on a dot, issue, then capture data.
module vram_arbiter
    import ppu_types_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                dot_en,
    input  logic                lcd_en,
    input  logic                mode3,
    input  logic                bg_req,
    input  logic [15:0]         bg_addr,
    input  logic                obj_req,
    input  logic [15:0]         obj_addr,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [15:0]         cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                bg_gnt,
    output logic                obj_gnt,
    output logic                cpu_gnt,
    output logic                bg_rvalid,
    output logic                obj_rvalid,
    output logic                cpu_done,
    output logic [7:0]          rdata,
    output logic [7:0]          cpu_rdata,
    output logic [VRAM_AW-1:0]  vram_addr,
    output logic                vram_re,
    output logic                vram_we,
    output logic [7:0]          vram_wdata,
    input  logic [7:0]          vram_rdata
);

    arb_state_t          state_q, state_d;
    vram_owner_t         owner_q, owner_d, pick;
    logic                we_q, we_d;
    logic                locked_q, locked_d;
    logic                fetch_mode;
    logic [VRAM_AW-1:0]  pick_addr;

    logic [VRAM_AW-1:0]  vram_addr_d;
    logic                vram_re_d, vram_we_d;
    logic [7:0]          vram_wdata_d, rdata_d, cpu_rdata_d;
    logic                bg_gnt_d, obj_gnt_d, cpu_gnt_d;
    logic                bg_rvalid_d, obj_rvalid_d, cpu_done_d;

    // VRAM is 8 KiB, so the top three address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bg_addr[15:13], obj_addr[15:13], cpu_addr[15:13]};

    assign fetch_mode = lcd_en & mode3;

    // During pixel transfer the fetchers own VRAM (sprites first); a CPU
    // request is still accepted but completes as a locked-out access.
    always_comb begin
        pick      = NONE;
        pick_addr = cpu_addr[VRAM_AW-1:0];
        if (fetch_mode) begin
            if (obj_req) begin
                pick      = OBJ;
                pick_addr = obj_addr[VRAM_AW-1:0];
            end else if (bg_req) begin
                pick      = BG;
                pick_addr = bg_addr[VRAM_AW-1:0];
            end else if (cpu_req) begin
                pick = CPU;
            end
        end else if (cpu_req) begin
            pick = CPU;
        end
    end

    always_comb begin
        // NOTE: every signal written here is defaulted first so no branch can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        locked_d     = locked_q;
        vram_addr_d  = vram_addr;
        vram_re_d    = 1'b0;
        vram_we_d    = 1'b0;
        vram_wdata_d = vram_wdata;
        rdata_d      = rdata;
        cpu_rdata_d  = cpu_rdata;
        bg_gnt_d     = 1'b0;
        obj_gnt_d    = 1'b0;
        cpu_gnt_d    = 1'b0;
        bg_rvalid_d  = 1'b0;
        obj_rvalid_d = 1'b0;
        cpu_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dot_en && pick != NONE) begin
                    state_d   = ISSUE;
                    owner_d   = pick;
                    we_d      = (pick == CPU) && cpu_we;
                    locked_d  = (pick == CPU) && fetch_mode;
                    bg_gnt_d  = (pick == BG);
                    obj_gnt_d = (pick == OBJ);
                    cpu_gnt_d = (pick == CPU);
                    // Port is registered, so strobes loaded here are high exactly during ISSUE.
                    if (!locked_d) begin
                        vram_addr_d = pick_addr;
                        vram_re_d   = !we_d;
                        vram_we_d   = we_d;
                        if (we_d) vram_wdata_d = cpu_wdata;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = IDLE;
                owner_d = NONE;
                case (owner_q)
                    BG: begin
                        rdata_d     = vram_rdata;
                        bg_rvalid_d = 1'b1;
                    end
                    OBJ: begin
                        rdata_d      = vram_rdata;
                        obj_rvalid_d = 1'b1;
                    end
                    CPU: begin
                        cpu_done_d = 1'b1;
                        if (locked_q)   cpu_rdata_d = OPEN_BUS;
                        else if (!we_q) cpu_rdata_d = vram_rdata;
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            we_q       <= 1'b0;
            locked_q   <= 1'b0;
            vram_addr  <= '0;
            vram_re    <= 1'b0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            rdata      <= '0;
            cpu_rdata  <= OPEN_BUS;
            bg_gnt     <= 1'b0;
            obj_gnt    <= 1'b0;
            cpu_gnt    <= 1'b0;
            bg_rvalid  <= 1'b0;
            obj_rvalid <= 1'b0;
            cpu_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            locked_q   <= locked_d;
            vram_addr  <= vram_addr_d;
            vram_re    <= vram_re_d;
            vram_we    <= vram_we_d;
            vram_wdata <= vram_wdata_d;
            rdata      <= rdata_d;
            cpu_rdata  <= cpu_rdata_d;
            bg_gnt     <= bg_gnt_d;
            obj_gnt    <= obj_gnt_d;
            cpu_gnt    <= cpu_gnt_d;
            bg_rvalid  <= bg_rvalid_d;
            obj_rvalid <= obj_rvalid_d;
            cpu_done   <= cpu_done_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural VRAM, a scoreboard of
// expected completions, and directed arbitration/lockout/reset scenarios.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset, dot_en, lcd_en, mode3;
    logic        bg_req, obj_req, cpu_req, cpu_we;
    logic [15:0] bg_addr, obj_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        bg_gnt, obj_gnt, cpu_gnt, bg_rvalid, obj_rvalid, cpu_done;
    logic [7:0]  rdata, cpu_rdata, vram_wdata, vram_rdata;
    logic [12:0] vram_addr;
    logic        vram_re, vram_we;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .lcd_en(lcd_en), .mode3(mode3),
        .bg_req(bg_req), .bg_addr(bg_addr), .obj_req(obj_req), .obj_addr(obj_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .bg_gnt(bg_gnt), .obj_gnt(obj_gnt), .cpu_gnt(cpu_gnt),
        .bg_rvalid(bg_rvalid), .obj_rvalid(obj_rvalid), .cpu_done(cpu_done),
        .rdata(rdata), .cpu_rdata(cpu_rdata),
        .vram_addr(vram_addr), .vram_re(vram_re), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Background VRAM content for never-written locations.
    function automatic logic [7:0] pat(input logic [12:0] a);
        if (a == 13'h1800) return 8'h3C;
        return a[7:0] ^ 8'h96;
    endfunction

    // Behavioural VRAM: synchronous, read data one clk after address.
    logic [7:0] mem [0:8191];
    bit         mem_valid [0:8191];
    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr]       <= vram_wdata;
            mem_valid[vram_addr] <= 1'b1;
        end
        if (vram_re) vram_rdata <= mem_valid[vram_addr] ? mem[vram_addr] : pat(vram_addr);
    end

    // Bench-side reference of what VRAM should contain.
    logic [7:0] shadow [0:8191];
    bit         shadow_valid [0:8191];
    function automatic logic [7:0] model_rd(input logic [12:0] a);
        return shadow_valid[a] ? shadow[a] : pat(a);
    endfunction

    typedef struct {
        int         kind;     // 0 bg, 1 obj, 2 cpu
        bit         is_read;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int          re_cnt = 0, we_cnt = 0, done_cnt = 0;
    int          bg_gnt_cnt = 0, obj_gnt_cnt = 0, cpu_gnt_cnt = 0;
    logic [12:0] last_re_addr = '0, last_we_addr = '0;

    // Completion monitor: pops the scoreboard on every rvalid/done pulse.
    always @(negedge clk) begin
        if (vram_re) begin re_cnt++; last_re_addr = vram_addr; end
        if (vram_we) begin we_cnt++; last_we_addr = vram_addr; end
        if (bg_gnt)  bg_gnt_cnt++;
        if (obj_gnt) obj_gnt_cnt++;
        if (cpu_gnt) cpu_gnt_cnt++;
        if (bg_rvalid || obj_rvalid || cpu_done) begin
            int   kind;
            exp_t e;
            done_cnt++;
            kind = bg_rvalid ? 0 : (obj_rvalid ? 1 : 2);
            check("done_onehot", 32'(bg_rvalid) + 32'(obj_rvalid) + 32'(cpu_done), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("done_owner", kind, e.kind);
                if (e.is_read) begin
                    if (kind == 2) check("cpu_rdata", cpu_rdata, e.data);
                    else           check("rdata", rdata, e.data);
                end
            end
        end
    end

    function automatic logic gnt_of(input int who);
        return (who == 0) ? bg_gnt : (who == 1) ? obj_gnt : cpu_gnt;
    endfunction

    function automatic logic done_of(input int who);
        return (who == 0) ? bg_rvalid : (who == 1) ? obj_rvalid : cpu_done;
    endfunction

    task automatic set_req(input int who, input logic v);
        if (who == 0) bg_req = v;
        else if (who == 1) obj_req = v;
        else cpu_req = v;
    endtask

    // Raise a request and, when tracked, push its expected completion.
    task automatic issue(input int who, input logic [15:0] addr, input bit we,
                         input logic [7:0] wd, input logic [7:0] exp, input bit track);
        exp_t e;
        if (track) begin
            e.kind = who; e.is_read = !we; e.data = exp;
            exp_q.push_back(e);
        end
        if (who == 0) bg_addr = addr;
        else if (who == 1) obj_addr = addr;
        else begin cpu_addr = addr; cpu_we = we; cpu_wdata = wd; end
        set_req(who, 1'b1);
    endtask

    task automatic wait_gnt(input int who, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waited++;
            if (gnt_of(who)) begin ok = 1'b1; break; end
        end
        if (!ok) check("gnt_timeout", 0, 1);
        set_req(who, 1'b0);
    endtask

    // Wait for grant, drop the request, then require completion 2 clk later.
    task automatic complete(input int who, input bit flip_mode3, output int waited);
        bit ok;
        wait_gnt(who, ok, waited);
        if (!ok) return;
        if (flip_mode3) mode3 = 1'b1;
        @(negedge clk);
        check("gnt_one_pulse", gnt_of(who), 0);
        @(negedge clk);
        check("done_latency", done_of(who), 1);
    endtask

    initial begin
        int  w, r0, w0, g0, d0;
        bit  ok;
        reset = 1'b1; dot_en = 1'b1; lcd_en = 1'b1; mode3 = 1'b1;
        bg_req = 0; obj_req = 0; cpu_req = 0; cpu_we = 0;
        bg_addr = '0; obj_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_pulses", {bg_gnt, obj_gnt, cpu_gnt, bg_rvalid, obj_rvalid, cpu_done, vram_re, vram_we}, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_vram_wdata", vram_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // BG fetch during mode3.
        r0 = re_cnt;
        issue(0, 16'h9800, 0, 8'h00, 8'h3C, 1);
        complete(0, 0, w);
        check("bg_re_cycles", re_cnt - r0, 1);
        check("bg_re_addr", last_re_addr, 13'h1800);

        // dot_en=0 holds off arbitration; upper address bits are dropped.
        dot_en = 1'b0;
        g0 = obj_gnt_cnt;
        issue(1, 16'hE123, 0, 8'h00, model_rd(13'h0123), 1);
        repeat (4) @(negedge clk);
        check("dot_en_gate", obj_gnt_cnt - g0, 0);
        dot_en = 1'b1;
        complete(1, 0, w);
        check("obj_addr_trunc", last_re_addr, 13'h0123);

        // Simultaneous obj+bg: obj first, bg on the next eligible dot.
        g0 = bg_gnt_cnt;
        issue(1, 16'h8200, 0, 8'h00, model_rd(13'h0200), 1);
        issue(0, 16'h9810, 0, 8'h00, model_rd(13'h1810), 1);
        complete(1, 0, w);
        check("bg_held_off", bg_gnt_cnt - g0, 0);
        complete(0, 0, w);
        check("bg_next_dot", w, 1);

        // Locked-out CPU read and write.
        r0 = re_cnt; w0 = we_cnt;
        issue(2, 16'h8000, 0, 8'h00, 8'hFF, 1);
        complete(2, 0, w);
        issue(2, 16'h8010, 1, 8'hA5, 8'h00, 1);
        complete(2, 0, w);
        check("locked_no_re", re_cnt - r0, 0);
        check("locked_no_we", we_cnt - w0, 0);

        // PPU not in mode3: CPU owns VRAM, held bg_req never granted.
        mode3 = 1'b0;
        bg_addr = 16'h9800; bg_req = 1'b1;
        g0 = bg_gnt_cnt; w0 = we_cnt;
        issue(2, 16'h8010, 1, 8'hA5, 8'h00, 1);
        shadow[13'h0010] = 8'hA5; shadow_valid[13'h0010] = 1'b1;
        complete(2, 0, w);
        check("cpu_we_cycles", we_cnt - w0, 1);
        check("cpu_we_addr", last_we_addr, 13'h0010);
        issue(2, 16'h8010, 0, 8'h00, model_rd(13'h0010), 1);
        complete(2, 0, w);
        lcd_en = 1'b0; mode3 = 1'b1;
        issue(2, 16'h8010, 0, 8'h00, model_rd(13'h0010), 1);
        complete(2, 0, w);
        check("bg_never_gnt", bg_gnt_cnt - g0, 0);
        bg_req = 1'b0;

        // mode3 rises while a CPU write is in flight.
        lcd_en = 1'b1; mode3 = 1'b0;
        w0 = we_cnt;
        issue(2, 16'h8020, 1, 8'h5A, 8'h00, 1);
        shadow[13'h0020] = 8'h5A; shadow_valid[13'h0020] = 1'b1;
        complete(2, 1, w);
        check("inflight_we", we_cnt - w0, 1);
        check("inflight_we_addr", last_we_addr, 13'h0020);
        issue(0, 16'h9830, 0, 8'h00, model_rd(13'h1830), 1);
        complete(0, 0, w);
        check("fetch_after_flip", w, 1);
        mode3 = 1'b0;
        issue(2, 16'h8020, 0, 8'h00, model_rd(13'h0020), 1);
        complete(2, 0, w);

        // Asynchronous reset during WAIT aborts the transaction.
        issue(2, 16'h8010, 0, 8'h00, 8'h00, 0);
        wait_gnt(2, ok, w);
        @(negedge clk);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check("arst_cpu_rdata", cpu_rdata, 8'hFF);
        check("arst_rdata", rdata, 0);
        check("arst_vram_addr", vram_addr, 0);
        check("arst_pulses", {cpu_gnt, cpu_done, vram_re, vram_we}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
